// File: rtl/req_capture_encoder.sv
// Request capture + priority encoder front end; optional macro EDGE_DETECT_EN selects rising-edge events.
// Latency: event at edge t lands in pending at t, code/valid load at edge t+1 when the slot is free.
// Backpressure: valid && !ready holds code/valid stable while pending keeps accumulating requests.
module req_capture_encoder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] code,
  output logic [N-1:0] pending,
  output logic         overflow
);

  logic         valid_q, valid_d;
  logic [W-1:0] code_q, code_d;
  logic [N-1:0] pending_q, pending_d;
  logic         overflow_q, overflow_d;

  logic [N-1:0] req_evt;
  logic [N-1:0] load_mask;
  logic [W-1:0] enc_idx;
  logic         slot_free;

`ifdef EDGE_DETECT_EN
  logic [N-1:0] req_q, req_d;

  // A request event is a rising edge relative to last cycle's sampled lines.
  always_comb begin
    req_d   = req;
    req_evt = req & ~req_q;
  end

  // Edge history; clears on reset so a line already high counts as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end
`else
  // Level mode: every sampled high line is an event, so a held line is re-served.
  always_comb begin
    req_evt = req;
  end
`endif

  // Pick the highest pending index, load it when the slot is free, and merge new events.
  always_comb begin
    slot_free = !valid_q || ready;
    enc_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) begin
        enc_idx = W'(i);
      end
    end

    load_mask = '0;
    valid_d   = valid_q;
    code_d    = code_q;
    if (slot_free) begin
      if (|pending_q) begin
        valid_d   = 1'b1;
        code_d    = enc_idx;
        load_mask = N'(1) << enc_idx;
      end else begin
        // Nothing to serve: drop valid but keep the last code visible.
        valid_d = 1'b0;
      end
    end

    // Set wins over the clear of a bit being loaded at the same edge.
    pending_d  = (pending_q & ~load_mask) | req_evt;
    // Only an event that merges into a bit staying pending counts as overflow.
    overflow_d = |(req_evt & pending_q & ~load_mask);
  end

  // Output and pending state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      code_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      code_q     <= code_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid    = valid_q;
  assign code     = code_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_req_capture_encoder.sv
// Directed bench for req_capture_encoder (N=4, W=2); each scenario checks hand-computed values.
module tb_req_capture_encoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ready;
  logic       valid;
  logic [1:0] code;
  logic [3:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  req_capture_encoder #(.N(4), .W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ready    (ready),
    .valid    (valid),
    .code     (code),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change here too, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req   = 4'b0000;
    ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (code !== 2'b00) begin errors++; $display("FAIL reset_code got %b want 00", code); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b want 0000", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    ready = 1'b1;
    req   = 4'b0001;
    step();
    req = 4'b0000;
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL single_pend got %b want 0001", pending); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_v0 got %b want 0", valid); end
    step();
    checks++; if (valid !== 1'b1 || code !== 2'b00) begin errors++; $display("FAIL single_load got v=%b c=%b want v=1 c=00", valid, code); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_clr got %b want 0000", pending); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b want 0", valid); end
    checks++; if (code !== 2'b00) begin errors++; $display("FAIL single_code_hold got %b want 00", code); end
  endtask

  task automatic test_priority_stall();
    ready = 1'b0;
    req   = 4'b0101;
    step();
    req = 4'b0000;
    step();
    checks++; if (valid !== 1'b1 || code !== 2'b10) begin errors++; $display("FAIL prio_load got v=%b c=%b want v=1 c=10", valid, code); end
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL prio_pend got %b want 0001", pending); end
    step();
    checks++; if (valid !== 1'b1 || code !== 2'b10) begin errors++; $display("FAIL prio_stall got v=%b c=%b want v=1 c=10", valid, code); end
    ready = 1'b1;
    step();
    checks++; if (valid !== 1'b1 || code !== 2'b00) begin errors++; $display("FAIL prio_next got v=%b c=%b want v=1 c=00", valid, code); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL prio_empty got %b want 0000", pending); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL prio_drop got %b want 0", valid); end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    req   = 4'b0011;
    step();
    req = 4'b0000;
    step();
    checks++; if (valid !== 1'b1 || code !== 2'b01) begin errors++; $display("FAIL ovf_load got v=%b c=%b want v=1 c=01", valid, code); end
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL ovf_pend got %b want 0001", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_quiet got %b want 0", overflow); end
    req = 4'b0001;
    step();
    req = 4'b0000;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", overflow); end
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL ovf_merge got %b want 0001", pending); end
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b want 0", overflow); end
    checks++; if (valid !== 1'b1 || code !== 2'b01) begin errors++; $display("FAIL ovf_hold got v=%b c=%b want v=1 c=01", valid, code); end
  endtask

  task automatic test_mid_reset();
    ready = 1'b0;
    req   = 4'b0100;
    step();
    req = 4'b1010;
    step();
    req = 4'b0000;
    checks++; if (valid !== 1'b1 || code !== 2'b10) begin errors++; $display("FAIL mrst_pre got v=%b c=%b want v=1 c=10", valid, code); end
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL mrst_pend got %b want 1010", pending); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({valid, code, pending, overflow} !== 8'b0) begin errors++; $display("FAIL mrst_async got v=%b c=%b p=%b o=%b want all 0", valid, code, pending, overflow); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (valid !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL mrst_after%0d got v=%b p=%b want v=0 p=0000", i, valid, pending); end
    end
  endtask

  task automatic test_held_line();
    ready = 1'b1;
    req   = 4'b1000;
    step();
    checks++; if (pending !== 4'b1000 || valid !== 1'b0) begin errors++; $display("FAIL held_first got p=%b v=%b want p=1000 v=0", pending, valid); end
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef EDGE_DETECT_EN
      if (i == 0) begin
        checks++; if (valid !== 1'b1 || code !== 2'b11) begin errors++; $display("FAIL held_beat got v=%b c=%b want v=1 c=11", valid, code); end
      end else begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL held_once%0d got %b want 0", i, valid); end
      end
`else
      checks++; if (valid !== 1'b1 || code !== 2'b11) begin errors++; $display("FAIL held_cont%0d got v=%b c=%b want v=1 c=11", i, valid, code); end
      checks++; if (pending !== 4'b1000 || overflow !== 1'b0) begin errors++; $display("FAIL held_pend%0d got p=%b o=%b want p=1000 o=0", i, pending, overflow); end
`endif
    end
    req = 4'b0000;
    step();
`ifdef EDGE_DETECT_EN
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL held_fall got %b want 0", valid); end
`else
    checks++; if (valid !== 1'b1 || code !== 2'b11 || pending !== 4'b0000) begin errors++; $display("FAIL held_last got v=%b c=%b p=%b want v=1 c=11 p=0000", valid, code, pending); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL held_drop got %b want 0", valid); end
`endif
    checks++; if (code !== 2'b11) begin errors++; $display("FAIL held_code_hold got %b want 11", code); end
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
    test_reset();
    test_single();
    drain();
    test_priority_stall();
    drain();
    test_overflow();
    drain();
    test_mid_reset();
    drain();
    test_held_line();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
